// File: rtl/segre_id_issue.sv
// segre_id_issue: decode-to-execute issue stage.
// Reads operands from the register file, tracks in-flight register writes in
// a per-register counter scoreboard, forwards from bypass ports, stalls on
// unresolved RAW and counter-saturation hazards, and presents one registered
// instruction to EX over a valid/ready handshake. A flush squashes the held
// instruction and returns its scoreboard reservation.
module segre_id_issue #(
  parameter int WORD_W  = 32,
  parameter int NREGS   = 32,
  parameter int NUM_BYP = 2,
  parameter int CNT_W   = 2,
  parameter int CTRL_W  = 16,
  localparam int REG_W  = $clog2(NREGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  // upstream handshake and pre-decoded instruction
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [WORD_W-1:0]         in_pc_i,
  input  logic [WORD_W-1:0]         in_imm_i,
  input  logic [REG_W-1:0]          in_rs1_i,
  input  logic [REG_W-1:0]          in_rs2_i,
  input  logic [REG_W-1:0]          in_rd_i,
  input  logic                      in_use_rs1_i,
  input  logic                      in_use_rs2_i,
  input  logic                      in_we_i,
  input  logic                      in_src_a_pc_i,
  input  logic                      in_src_b_imm_i,
  input  logic [CTRL_W-1:0]         in_ctrl_i,
  // register file read ports
  output logic [REG_W-1:0]          rf_raddr_a_o,
  output logic [REG_W-1:0]          rf_raddr_b_o,
  input  logic [WORD_W-1:0]         rf_data_a_i,
  input  logic [WORD_W-1:0]         rf_data_b_i,
  // bypass ports, index 0 is the youngest producer
  input  logic [NUM_BYP-1:0]        byp_valid_i,
  input  logic [NUM_BYP*REG_W-1:0]  byp_addr_i,
  input  logic [NUM_BYP*WORD_W-1:0] byp_data_i,
  // register file write commit
  input  logic                      wb_valid_i,
  input  logic [REG_W-1:0]          wb_addr_i,
  // downstream handshake to EX
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [WORD_W-1:0]         out_pc_o,
  output logic [WORD_W-1:0]         out_src_a_o,
  output logic [WORD_W-1:0]         out_src_b_o,
  output logic [WORD_W-1:0]         out_store_data_o,
  output logic [REG_W-1:0]          out_rd_o,
  output logic                      out_we_o,
  output logic [CTRL_W-1:0]         out_ctrl_o,
  output logic                      hazard_stall_o
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // scoreboard
  logic [CNT_W-1:0]  r_cnt     [NREGS];
  logic [CNT_W-1:0]  w_cnt_nxt [NREGS];
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_dec;

  // output register
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_pc;
  logic [WORD_W-1:0] r_out_src_a;
  logic [WORD_W-1:0] r_out_src_b;
  logic [WORD_W-1:0] r_out_store_data;
  logic [REG_W-1:0]  r_out_rd;
  logic              r_out_we;
  logic [CTRL_W-1:0] r_out_ctrl;

  // operand resolution
  logic [CNT_W-1:0]  w_cnt_a;
  logic [CNT_W-1:0]  w_cnt_b;
  logic [CNT_W-1:0]  w_cnt_rd;
  logic              w_byp_hit_a;
  logic              w_byp_hit_b;
  logic [WORD_W-1:0] w_byp_data_a;
  logic [WORD_W-1:0] w_byp_data_b;
  logic [WORD_W-1:0] w_op_a;
  logic [WORD_W-1:0] w_op_b;
  logic              w_haz_a;
  logic              w_haz_b;
  logic              w_haz_struct;
  logic              w_hazard;
  logic              w_out_free;
  logic              w_issue;
  logic              w_flush_drop;

  assign rf_raddr_a_o = in_rs1_i;
  assign rf_raddr_b_o = in_rs2_i;

  assign w_cnt_a  = r_cnt[in_rs1_i];
  assign w_cnt_b  = r_cnt[in_rs2_i];
  assign w_cnt_rd = r_cnt[in_rd_i];

  // Pick the lowest-index matching bypass port for each source; scanning
  // downwards lets the lowest index overwrite any higher-index match.
  always_comb begin
    w_byp_hit_a  = 1'b0;
    w_byp_hit_b  = 1'b0;
    w_byp_data_a = '0;
    w_byp_data_b = '0;
    for (int i = NUM_BYP - 1; i >= 0; i--) begin
      if (byp_valid_i[i] && (byp_addr_i[i*REG_W +: REG_W] == in_rs1_i)) begin
        w_byp_hit_a  = 1'b1;
        w_byp_data_a = byp_data_i[i*WORD_W +: WORD_W];
      end
      if (byp_valid_i[i] && (byp_addr_i[i*REG_W +: REG_W] == in_rs2_i)) begin
        w_byp_hit_b  = 1'b1;
        w_byp_data_b = byp_data_i[i*WORD_W +: WORD_W];
      end
    end
  end

  // Resolve operand A: RF when idle, bypass only with a single producer in
  // flight, hazard otherwise. x0 and unused sources never hazard.
  always_comb begin
    w_op_a  = rf_data_a_i;
    w_haz_a = 1'b0;
    if ((w_cnt_a == CNT_ONE) && w_byp_hit_a) begin
      w_op_a = w_byp_data_a;
    end else if (w_cnt_a != CNT_ZERO) begin
      w_haz_a = 1'b1;
    end
    if (!in_use_rs1_i || (in_rs1_i == REG_ZERO)) begin
      w_haz_a = 1'b0;
    end
  end

  // Resolve operand B with the same rules as operand A.
  always_comb begin
    w_op_b  = rf_data_b_i;
    w_haz_b = 1'b0;
    if ((w_cnt_b == CNT_ONE) && w_byp_hit_b) begin
      w_op_b = w_byp_data_b;
    end else if (w_cnt_b != CNT_ZERO) begin
      w_haz_b = 1'b1;
    end
    if (!in_use_rs2_i || (in_rs2_i == REG_ZERO)) begin
      w_haz_b = 1'b0;
    end
  end

  // A saturated destination counter cannot take another reservation.
  assign w_haz_struct = in_we_i && (in_rd_i != REG_ZERO) && (w_cnt_rd == CNT_MAX);
  assign w_hazard     = in_valid_i && (w_haz_a || w_haz_b || w_haz_struct);
  assign w_out_free   = !r_out_valid || out_ready_i;

  assign in_ready_o     = !flush_i && !w_hazard && w_out_free;
  assign w_issue        = in_valid_i && in_ready_o;
  assign hazard_stall_o = w_hazard && !flush_i && w_out_free;

  // A squashed writer will never commit, so its reservation is returned.
  assign w_flush_drop = flush_i && r_out_valid && r_out_we && (r_out_rd != REG_ZERO);

  // Next scoreboard counts: issue reserves, commit and squash release,
  // releases below zero clamp at zero. x0 is never tracked.
  always_comb begin
    w_sum = '0;
    w_dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_sum = {2'b00, r_cnt[r]};
      w_dec = '0;
      if (w_issue && in_we_i && (in_rd_i == REG_W'(r))) begin
        w_sum = w_sum + SUM_W'(1);
      end
      if (wb_valid_i && (wb_addr_i == REG_W'(r))) begin
        w_dec = w_dec + SUM_W'(1);
      end
      if (w_flush_drop && (r_out_rd == REG_W'(r))) begin
        w_dec = w_dec + SUM_W'(1);
      end
      w_cnt_nxt[r] = (w_sum > w_dec) ? CNT_W'(w_sum - w_dec) : CNT_ZERO;
      if (r == 0) begin
        w_cnt_nxt[r] = CNT_ZERO;
      end
    end
  end

  // Scoreboard counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '{default: '0};
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Output register: flush squashes, issue loads, acceptance empties,
  // otherwise the payload holds stable for EX.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid      <= 1'b0;
      r_out_pc         <= '0;
      r_out_src_a      <= '0;
      r_out_src_b      <= '0;
      r_out_store_data <= '0;
      r_out_rd         <= '0;
      r_out_we         <= 1'b0;
      r_out_ctrl       <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_issue) begin
      r_out_valid      <= 1'b1;
      r_out_pc         <= in_pc_i;
      r_out_src_a      <= in_src_a_pc_i ? in_pc_i : w_op_a;
      r_out_src_b      <= in_src_b_imm_i ? in_imm_i : w_op_b;
      r_out_store_data <= w_op_b;
      r_out_rd         <= in_rd_i;
      r_out_we         <= in_we_i;
      r_out_ctrl       <= in_ctrl_i;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o      = r_out_valid;
  assign out_pc_o         = r_out_pc;
  assign out_src_a_o      = r_out_src_a;
  assign out_src_b_o      = r_out_src_b;
  assign out_store_data_o = r_out_store_data;
  assign out_rd_o         = r_out_rd;
  assign out_we_o         = r_out_we;
  assign out_ctrl_o       = r_out_ctrl;

endmodule

// File: tb/tb_segre_id_issue.sv
// Bench for segre_id_issue: directed scenarios followed by random traffic,
// with expected EX payloads queued at issue and popped by a separate monitor.
module tb_segre_id_issue;
  localparam int WORD_W  = 32;
  localparam int NREGS   = 32;
  localparam int NUM_BYP = 2;
  localparam int CNT_W   = 2;
  localparam int CTRL_W  = 16;
  localparam int REG_W   = 5;
  localparam int CNT_CAP = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  logic in_valid_i, in_ready_o;
  logic [WORD_W-1:0] in_pc_i, in_imm_i;
  logic [REG_W-1:0] in_rs1_i, in_rs2_i, in_rd_i;
  logic in_use_rs1_i, in_use_rs2_i, in_we_i, in_src_a_pc_i, in_src_b_imm_i;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [REG_W-1:0] rf_raddr_a_o, rf_raddr_b_o;
  logic [WORD_W-1:0] rf_data_a_i, rf_data_b_i;
  logic [NUM_BYP-1:0] byp_valid_i;
  logic [NUM_BYP*REG_W-1:0] byp_addr_i;
  logic [NUM_BYP*WORD_W-1:0] byp_data_i;
  logic wb_valid_i;
  logic [REG_W-1:0] wb_addr_i;
  logic out_valid_o, out_ready_i;
  logic [WORD_W-1:0] out_pc_o, out_src_a_o, out_src_b_o, out_store_data_o;
  logic [REG_W-1:0] out_rd_o;
  logic out_we_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic hazard_stall_o;

  logic [WORD_W-1:0] tb_rf [NREGS];
  assign rf_data_a_i = tb_rf[rf_raddr_a_o];
  assign rf_data_b_i = tb_rf[rf_raddr_b_o];

  always #5 clk_i = ~clk_i;

  segre_id_issue #(.WORD_W(WORD_W), .NREGS(NREGS), .NUM_BYP(NUM_BYP),
                   .CNT_W(CNT_W), .CTRL_W(CTRL_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_pc_i(in_pc_i), .in_imm_i(in_imm_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i),
    .in_use_rs1_i(in_use_rs1_i), .in_use_rs2_i(in_use_rs2_i), .in_we_i(in_we_i),
    .in_src_a_pc_i(in_src_a_pc_i), .in_src_b_imm_i(in_src_b_imm_i),
    .in_ctrl_i(in_ctrl_i),
    .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o),
    .rf_data_a_i(rf_data_a_i), .rf_data_b_i(rf_data_b_i),
    .byp_valid_i(byp_valid_i), .byp_addr_i(byp_addr_i), .byp_data_i(byp_data_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_src_a_o(out_src_a_o), .out_src_b_o(out_src_b_o),
    .out_store_data_o(out_store_data_o), .out_rd_o(out_rd_o), .out_we_o(out_we_o),
    .out_ctrl_o(out_ctrl_o), .hazard_stall_o(hazard_stall_o)
  );

  typedef struct {
    logic [WORD_W-1:0] pc, a, b, sd;
    logic chk_a, chk_b, chk_sd;
    logic [REG_W-1:0] rd;
    logic we;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: pending-write count per register, the held EX entry,
  // and the list of destinations accepted by EX but not yet committed
  int   m_cnt [NREGS];
  bit   m_ov;
  exp_t m_held;
  int   inflight[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void resolve(input int r, output bit haz, output logic [WORD_W-1:0] v);
    bit found = 0;
    haz = 0;
    v   = tb_rf[r];
    if (r != 0 && m_cnt[r] == 1) begin
      for (int i = 0; i < NUM_BYP; i++)
        if (!found && byp_valid_i[i] && int'(byp_addr_i[i*REG_W +: REG_W]) == r) begin
          found = 1;
          v = byp_data_i[i*WORD_W +: WORD_W];
        end
      haz = !found;
    end else if (r != 0 && m_cnt[r] >= 2) begin
      haz = 1;
    end
  endfunction

  // One clock cycle with the inputs already driven at the falling edge.
  task automatic step();
    bit ha, hb, hs, haz, rdy, iss, free;
    logic [WORD_W-1:0] va, vb;
    exp_t e;
    #1;
    resolve(int'(in_rs1_i), ha, va);
    resolve(int'(in_rs2_i), hb, vb);
    hs   = in_we_i && in_rd_i != 0 && m_cnt[in_rd_i] == CNT_CAP;
    haz  = in_valid_i && ((in_use_rs1_i && ha) || (in_use_rs2_i && hb) || hs);
    free = !m_ov || out_ready_i;
    rdy  = !flush_i && !haz && free;
    check("in_ready", in_ready_o, rdy);
    check("hazard_stall", hazard_stall_o, haz && !flush_i && free);
    iss = in_valid_i && rdy;
    e.pc = in_pc_i;
    e.a = in_src_a_pc_i ? in_pc_i : va;
    e.chk_a = in_src_a_pc_i || in_use_rs1_i;
    e.b = in_src_b_imm_i ? in_imm_i : vb;
    e.chk_b = in_src_b_imm_i || in_use_rs2_i;
    e.sd = vb;
    e.chk_sd = in_use_rs2_i;
    e.rd = in_rd_i;
    e.we = in_we_i;
    e.ctrl = in_ctrl_i;
    if (flush_i && m_ov && m_held.we && m_held.rd != 0)
      m_cnt[m_held.rd]--;
    else if (!flush_i && m_ov && out_ready_i && m_held.we && m_held.rd != 0)
      inflight.push_back(int'(m_held.rd));
    if (wb_valid_i && wb_addr_i != 0 && m_cnt[wb_addr_i] > 0)
      m_cnt[wb_addr_i]--;
    if (iss && in_we_i && in_rd_i != 0)
      m_cnt[in_rd_i]++;
    if (flush_i) m_ov = 0;
    else if (iss) m_ov = 1;
    else if (out_ready_i) m_ov = 0;
    if (iss) m_held = e;
    #3;
    if (iss) exp_q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    flush_i = 0; in_valid_i = 0; in_pc_i = '0; in_imm_i = '0;
    in_rs1_i = '0; in_rs2_i = '0; in_rd_i = '0;
    in_use_rs1_i = 0; in_use_rs2_i = 0; in_we_i = 0;
    in_src_a_pc_i = 0; in_src_b_imm_i = 0; in_ctrl_i = '0;
    byp_valid_i = '0; byp_addr_i = '0; byp_data_i = '0;
    wb_valid_i = 0; wb_addr_i = '0; out_ready_i = 1;
  endtask

  task automatic instr(input int rs1, input int rs2, input int rd,
                       input bit use1, input bit use2, input bit we);
    in_valid_i = 1; in_pc_i = $urandom; in_imm_i = $urandom; in_ctrl_i = CTRL_W'($urandom);
    in_rs1_i = REG_W'(rs1); in_rs2_i = REG_W'(rs2); in_rd_i = REG_W'(rd);
    in_use_rs1_i = use1; in_use_rs2_i = use2; in_we_i = we;
    in_src_a_pc_i = 0; in_src_b_imm_i = 0;
  endtask

  task automatic retire(input int r);
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i] == r) begin
        inflight.delete(i);
        wb_valid_i = 1;
        wb_addr_i = REG_W'(r);
        return;
      end
  endtask

  // Monitor: every cycle the queue must mirror out_valid_o; on acceptance the
  // head is compared, on a flush it is discarded.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i) begin
        check("out_valid_vs_queue", out_valid_o, exp_q.size() != 0);
        if (out_valid_o && exp_q.size() > 0) begin
          if (flush_i) begin
            void'(exp_q.pop_front());
          end else if (out_ready_i) begin
            e = exp_q.pop_front();
            check("out_pc", out_pc_o, e.pc);
            check("out_rd", out_rd_o, e.rd);
            check("out_we", out_we_o, e.we);
            check("out_ctrl", out_ctrl_o, e.ctrl);
            if (e.chk_a) check("out_src_a", out_src_a_o, e.a);
            if (e.chk_b) check("out_src_b", out_src_b_o, e.b);
            if (e.chk_sd) check("out_store_data", out_store_data_o, e.sd);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int idx;
    for (int i = 0; i < NREGS; i++) begin
      tb_rf[i] = (i == 0) ? '0 : $urandom;
      m_cnt[i] = 0;
    end
    m_ov = 0;
    rst_i = 1;
    idle_inputs();
    instr(3, 4, 5, 1, 1, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_we", out_we_o, 0);
    check("rst_hazard_stall", hazard_stall_o, 0);
    check("rst_out_src_a", out_src_a_o, 0);
    check("rst_out_pc", out_pc_o, 0);
    check("rst_out_ctrl", out_ctrl_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    idle_inputs();
    rst_i = 0;

    // three independent back-to-back ALU ops
    instr(1, 2, 10, 1, 1, 1); step();
    instr(3, 4, 11, 1, 1, 1); step();
    instr(5, 6, 12, 1, 1, 1); step();
    idle_inputs(); step();

    // RAW on x5 without bypass, released by a write commit
    instr(1, 2, 5, 1, 1, 1); step();
    instr(5, 0, 6, 1, 0, 1); step();
    step();
    retire(5); step();
    wb_valid_i = 0; step();
    idle_inputs(); step();

    // RAW on x5 resolved in the same cycle through bypass port 1
    instr(1, 2, 5, 1, 1, 1); step();
    instr(5, 0, 13, 1, 0, 0);
    byp_valid_i = 2'b10;
    byp_addr_i = {REG_W'(5), REG_W'(9)};
    byp_data_i = {32'hDEAD_BEEF, 32'h0BAD_F00D};
    step();
    check("bypass_src_a", out_src_a_o, 32'hDEAD_BEEF);
    idle_inputs(); step();

    // two writes to x7 in flight: stall at count 2, forward at count 1
    instr(1, 2, 7, 1, 1, 1); step();
    instr(3, 4, 7, 1, 1, 1); step();
    instr(7, 0, 14, 1, 0, 0);
    byp_valid_i = 2'b01;
    byp_addr_i = {REG_W'(0), REG_W'(7)};
    byp_data_i = {32'h0, 32'h1234_5678};
    step();
    step();
    retire(7); step();
    wb_valid_i = 0; step();
    check("fwd_after_cnt1_src_a", out_src_a_o, 32'h1234_5678);
    idle_inputs(); step();

    // downstream back-pressure: payload must hold
    instr(8, 9, 15, 1, 1, 0); step();
    out_ready_i = 0;
    instr(1, 2, 16, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("hold_pc", out_pc_o, m_held.pc);
      check("hold_ctrl", out_ctrl_o, m_held.ctrl);
      check("hold_valid", out_valid_o, 1);
    end
    out_ready_i = 1; step();
    idle_inputs(); step();

    // flush of a held writer to x3 returns its reservation
    instr(1, 2, 3, 1, 1, 1); out_ready_i = 0; step();
    instr(4, 5, 17, 1, 1, 0); out_ready_i = 1; flush_i = 1; step();
    check("flush_out_valid", out_valid_o, 0);
    flush_i = 0;
    instr(3, 0, 18, 1, 0, 0); step();
    idle_inputs(); step();

    // commit to an idle register must not wrap its counter
    wb_valid_i = 1; wb_addr_i = 5'd20; step();
    wb_valid_i = 0;
    instr(20, 0, 19, 1, 0, 0); step();
    idle_inputs(); step();

    // asynchronous reset in the middle of a stall
    instr(1, 2, 8, 1, 1, 1); step();
    instr(8, 0, 21, 1, 0, 0); step();
    #3 rst_i = 1;
    #1;
    check("async_rst_out_valid", out_valid_o, 0);
    check("async_rst_hazard_stall", hazard_stall_o, 0);
    check("async_rst_out_src_a", out_src_a_o, 0);
    check("async_rst_out_we", out_we_o, 0);
    for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
    m_ov = 0;
    exp_q.delete();
    inflight.delete();
    @(negedge clk_i);
    rst_i = 0;
    idle_inputs();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      instr($urandom % 8, $urandom % 8, $urandom % 8,
            ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 2) != 0);
      in_valid_i = ($urandom % 4) != 0;
      in_src_a_pc_i = ($urandom % 4) == 0;
      in_src_b_imm_i = ($urandom % 2) != 0;
      out_ready_i = ($urandom % 4) != 0;
      flush_i = ($urandom % 16) == 0;
      byp_valid_i = NUM_BYP'($urandom);
      for (int i = 0; i < NUM_BYP; i++) begin
        byp_addr_i[i*REG_W +: REG_W] = REG_W'($urandom % 8);
        byp_data_i[i*WORD_W +: WORD_W] = $urandom;
      end
      if (inflight.size() > 0 && ($urandom % 2) != 0) begin
        idx = $urandom_range(inflight.size() - 1, 0);
        wb_valid_i = 1;
        wb_addr_i = REG_W'(inflight[idx]);
        inflight.delete(idx);
      end
      step();
    end

    idle_inputs();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/segre_id_issue.md
# segre_id_issue

Parametrised decode-to-execute issue stage for the Segre core and the successor of the fixed single-cycle ID stage. It accepts pre-decoded instructions from IF/decode over a valid/ready handshake and reads operands from the register file. It tracks in-flight register writes in a per-register scoreboard, forwards results from a configurable number of bypass ports, stalls on unresolved RAW hazards and supports flushes. It sits between the decoder and EX and replaces the FSM-state gating with handshakes.

## Interface
- WORD_W, 32, datapath width
- NREGS, 32, architectural registers; REG_W = $clog2(NREGS)
- NUM_BYP, 2, bypass ports; index 0 = youngest producer
- CNT_W, 2, scoreboard counter width per register
- CTRL_W, 16, opaque control bundle width (ALU opcode, memop type/rd/wr/sign-ext)

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  squash the stage (taken branch/jump resolved in EX)
- in_valid_i / in_ready_o  in/out  1  upstream handshake
- in_pc_i, in_imm_i  in  WORD_W  PC and selected immediate
- in_rs1_i, in_rs2_i, in_rd_i  in  REG_W  register indices
- in_use_rs1_i, in_use_rs2_i, in_we_i  in  1  operand usage and writeback enable
- in_src_a_pc_i, in_src_b_imm_i  in  1  ALU A = PC, ALU B = immediate
- in_ctrl_i  in  CTRL_W  control bundle
- rf_raddr_a_o, rf_raddr_b_o  out  REG_W  driven combinationally from in_rs1_i/in_rs2_i
- rf_data_a_i, rf_data_b_i  in  WORD_W  same-cycle RF read data
- byp_valid_i  in  NUM_BYP  bypass data valid
- byp_addr_i  in  NUM_BYP*REG_W  bypass destination registers
- byp_data_i  in  NUM_BYP*WORD_W  bypass values
- wb_valid_i, wb_addr_i  in  1, REG_W  RF write commit; decrements the scoreboard
- out_valid_o / out_ready_i  out/in  1  downstream handshake to EX
- out_pc_o, out_src_a_o, out_src_b_o, out_store_data_o  out  WORD_W  EX operands
- out_rd_o  out  REG_W; out_we_o  out  1; out_ctrl_o  out  CTRL_W
- hazard_stall_o  out  1  high in any cycle the stage is blocked only by a hazard

## Operation
- Scoreboard: one CNT_W counter per register. Register 0 is never pending and never hazards.
- Operand resolution, per used source r:
  - cnt[r]==0: use RF data.
  - cnt[r]==1: use the lowest-index bypass port with byp_valid_i and a matching address. If no port matches, hazard.
  - cnt[r]>=2: hazard, with no forwarding.
- Structural hazard: in_we_i and rd!=0 and cnt[rd] == 2^CNT_W-1.
- hazard = in_valid_i and (any operand hazard or structural hazard).
- in_ready_o = !flush_i and !hazard and (!out_valid_o or out_ready_i). This signal is combinational on the in_* fields.
- Issue (in_valid_i and in_ready_o) loads the output register:
  - out_src_a = in_src_a_pc_i ? pc : opA
  - out_src_b = in_src_b_imm_i ? imm : opB
  - out_store_data = opB
  - rd, we, ctrl and pc pass through unchanged.
  - cnt[rd] increments if we and rd!=0.
- Output not accepted and no issue: the output register holds and out_valid_o stays high.
- Accepted with no issue: out_valid_o clears.
- Scoreboard update: wb_valid_i with wb_addr_i!=0 decrements cnt[wb_addr_i]. An increment and a decrement on the same register in the same cycle leave the count unchanged. A decrement at 0 is an error condition; the counter holds at 0.
- Flush: out_valid_o clears next cycle and no issue happens that cycle. If the held entry had out_we_o with rd!=0, its counter decrements. This combines with a same-cycle wb decrement (net −2) or with nothing else (net −1). A flush overrides a same-cycle out_ready_i acceptance; EX discards the instruction.
- hazard_stall_o = hazard and !flush_i and (!out_valid_o or out_ready_i).

## Timing
- Reset values:
  - out_valid_o, out_we_o, hazard_stall_o: 0
  - all data and control outputs: 0
  - all counters: 0
- Reset mid-operation drops the held instruction immediately.
- Latency: one cycle from issue to out_valid_o.
- Throughput: one instruction per cycle with no hazards and out_ready_i high.
- A value arriving on a bypass port resolves the hazard in that same cycle (issue that cycle).
- A wb commit without a bypass releases the register on the next cycle; the RF read then supplies the value.
- Data on the out_* payload signals is stable while out_valid_o and !out_ready_i.

## Test plan
- Reset, then issue three independent ADDs back-to-back with out_ready_i=1 -> out_valid_o high for 3 consecutive cycles; operands equal the RF values; scoreboard counts rise.
- Issue `x5<-...`, then an instruction using x5 with no bypass -> stall and hazard_stall_o=1 until wb_valid_i/addr=5; issue follows the next cycle using RF data.
- Same pair with byp_valid_i[1]=1, addr 5, data 0xDEAD_BEEF -> issue in the same cycle; out_src_a_o=0xDEADBEEF.
- Two in-flight writes to x7, then a consumer with a matching bypass -> stall while cnt=2; forward once cnt=1.
- out_ready_i=0 for 4 cycles with out_valid_o high -> outputs held constant; in_ready_o=0.
- Flush with a held `we` to x3 (cnt[3]=1) -> out_valid_o=0 next cycle and cnt[3]=0. Assert rst_i mid-stall -> all outputs 0 asynchronously.
